// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin requester agent.
package rr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // Saturation value of a pending counter of the given width.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/rr_pend_cnt.sv
// Saturating per-client pending-request counter: +1 on inc, -1 on dec, floor at 0.
module rr_pend_cnt
    import rr_pkg::*;
#(
    parameter int CNTWIDTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc,
    input  logic                dec,
    output logic [CNTWIDTH-1:0] cnt,
    output logic                full,
    output logic                ovf
);

    localparam logic [CNTWIDTH-1:0] MAX = CNTWIDTH'(cnt_max(CNTWIDTH));

    assign full = (cnt == MAX);
    // A set that coincides with a retire cancels out, so it never overflows.
    assign ovf  = inc & ~dec & full;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    retire_on_empty : assert property (@(posedge clk_i) disable iff (!rst_i) dec |-> cnt != '0);

endmodule

// File: rtl/rr_req_agent.sv
// Requester side of the round-robin arbiter: counts client requests, issues
// request snapshots, captures the grant and hands it to a consumer.
module rr_req_agent
    import rr_pkg::*;
#(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int CNTWIDTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   req_set_i,
    output logic [REQCNT-1:0]   req_full_o,
    output logic [REQCNT-1:0]   req_o,
    output logic                req_val_o,
    input  logic [REQWIDTH-1:0] req_num_i,
    output logic                gnt_val_o,
    input  logic                gnt_rdy_i,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic [REQCNT-1:0]   gnt_oh_o,
    output logic                bad_gnt_o,
    output logic                ovf_o
);

    state_t              state, state_nxt;
    logic [REQCNT-1:0]   req_nxt;
    logic [REQWIDTH-1:0] gnt_num_nxt;
    logic                bad_nxt;
    logic [REQCNT-1:0]   pend, dec, ovf_pulse, gnt_bit;
    logic                gnt_ok;
    logic [CNTWIDTH-1:0] cnt [REQCNT];

    for (genvar c = 0; c < REQCNT; c++) begin : g_cnt
        rr_pend_cnt #(.CNTWIDTH(CNTWIDTH)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (req_set_i[c]),
            .dec   (dec[c]),
            .cnt   (cnt[c]),
            .full  (req_full_o[c]),
            .ovf   (ovf_pulse[c])
        );
        assign pend[c] = (cnt[c] != '0);
    end

    // An out-of-range index shifts the bit away, so it also fails the snapshot match.
    assign gnt_bit   = REQCNT'(1) << req_num_i;
    assign gnt_ok    = |(req_o & gnt_bit);
    assign req_val_o = (state == ISSUE);
    assign gnt_val_o = (state == WAIT);
    assign gnt_oh_o  = gnt_val_o ? (REQCNT'(1) << gnt_num_o) : '0;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        req_nxt     = req_o;
        gnt_num_nxt = gnt_num_o;
        bad_nxt     = bad_gnt_o;
        dec         = '0;
        case (state)
            IDLE: begin
                req_nxt = pend;
                if (|pend) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (gnt_ok) begin
                    dec         = gnt_bit;
                    gnt_num_nxt = req_num_i;
                    state_nxt   = WAIT;
                end else begin
                    bad_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (gnt_rdy_i) begin
                    req_nxt   = pend;
                    state_nxt = (|pend) ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            req_o     <= '0;
            gnt_num_o <= '0;
            bad_gnt_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_o     <= req_nxt;
            gnt_num_o <= gnt_num_nxt;
            bad_gnt_o <= bad_nxt;
            ovf_o     <= ovf_o | (|ovf_pulse);
        end
    end

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed self-checking bench for rr_req_agent; emulates a round-robin arbiter.
module tb_rr_req_agent;
    import rr_pkg::*;

    localparam int REQCNT   = 5;
    localparam int REQWIDTH = 3;
    localparam int CNTWIDTH = 3;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic [REQCNT-1:0]   req_set_i = '0;
    logic [REQCNT-1:0]   req_full_o;
    logic [REQCNT-1:0]   req_o;
    logic                req_val_o;
    logic [REQWIDTH-1:0] req_num_i = '0;
    logic                gnt_val_o;
    logic                gnt_rdy_i = 1'b0;
    logic [REQWIDTH-1:0] gnt_num_o;
    logic [REQCNT-1:0]   gnt_oh_o;
    logic                bad_gnt_o;
    logic                ovf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rr_req_agent #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH), .CNTWIDTH(CNTWIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_set_i  (req_set_i),
        .req_full_o (req_full_o),
        .req_o      (req_o),
        .req_val_o  (req_val_o),
        .req_num_i  (req_num_i),
        .gnt_val_o  (gnt_val_o),
        .gnt_rdy_i  (gnt_rdy_i),
        .gnt_num_o  (gnt_num_o),
        .gnt_oh_o   (gnt_oh_o),
        .bad_gnt_o  (bad_gnt_o),
        .ovf_o      (ovf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk_i);
    endtask

    // Arbiter model: first requested index at or after ptr, cyclically.
    function automatic logic [REQWIDTH-1:0] rr_pick(input logic [REQCNT-1:0] req, input int ptr);
        for (int i = 0; i < REQCNT; i++) begin
            int idx = (ptr + i) % REQCNT;
            if (req[idx]) return REQWIDTH'(idx);
        end
        return '1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ptr;
        int k;
        logic [REQWIDTH-1:0] exp_seq [4];
        exp_seq = '{3'd0, 3'd1, 3'd3, 3'd0};

        // Reset state
        tick(); tick();
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_req", 32'(req_o), 32'h0);
        check("rst_rv", 32'(req_val_o), 32'h0);
        check("rst_gv", 32'(gnt_val_o), 32'h0);
        check("rst_oh", 32'(gnt_oh_o), 32'h0);
        check("rst_full", 32'(req_full_o), 32'h0);
        check("rst_sticky", 32'({bad_gnt_o, ovf_o}), 32'h0);
        rst_i = 1'b1;
        tick();

        // Single request on client 2
        req_set_i = 5'b00100;
        tick();
        req_set_i = '0;
        check("t1_cnt_set", 32'(dut.cnt[2]), 32'd1);
        check("t1_rv_lat", 32'(req_val_o), 32'h0);
        tick();
        check("t1_rv", 32'(req_val_o), 32'h1);
        check("t1_req", 32'(req_o), 32'b00100);
        req_num_i = 3'd2;
        gnt_rdy_i = 1'b1;
        tick();
        check("t1_rv_once", 32'(req_val_o), 32'h0);
        check("t1_gv", 32'(gnt_val_o), 32'h1);
        check("t1_gnum", 32'(gnt_num_o), 32'd2);
        check("t1_oh", 32'(gnt_oh_o), 32'b00100);
        check("t1_cnt_ret", 32'(dut.cnt[2]), 32'd0);
        tick();
        check("t1_idle", 32'(dut.state), 32'(IDLE));
        check("t1_gv_off", 32'(gnt_val_o), 32'h0);
        check("t1_oh_off", 32'(gnt_oh_o), 32'h0);
        check("t1_req_clr", 32'(req_o), 32'h0);

        // Backpressure: grant held, new request on client 0 waits for the handshake
        gnt_rdy_i = 1'b0;
        req_set_i = 5'b00100;
        tick();
        req_set_i = '0;
        tick();
        req_num_i = 3'd2;
        tick();
        check("t2_gv", 32'(gnt_val_o), 32'h1);
        req_set_i = 5'b00001;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_set_i = '0;
            check($sformatf("t2_hold_gv%0d", i), 32'(gnt_val_o), 32'h1);
            check($sformatf("t2_hold_num%0d", i), 32'(gnt_num_o), 32'd2);
            check($sformatf("t2_hold_rv%0d", i), 32'(req_val_o), 32'h0);
        end
        gnt_rdy_i = 1'b1;
        tick();
        check("t2_reissue_rv", 32'(req_val_o), 32'h1);
        check("t2_reissue_req", 32'(req_o), 32'b00001);
        check("t2_gv_off", 32'(gnt_val_o), 32'h0);
        req_num_i = 3'd0;
        tick();
        check("t2_gnum0", 32'(gnt_num_o), 32'd0);
        check("t2_oh0", 32'(gnt_oh_o), 32'b00001);
        tick();
        check("t2_idle", 32'(dut.state), 32'(IDLE));

        // Round-robin drain of {c0=2, c1=1, c3=1}
        req_set_i = 5'b01011;
        tick();
        req_set_i = 5'b00001;
        tick();
        req_set_i = '0;
        check("t3_cnt0", 32'(dut.cnt[0]), 32'd2);
        ptr = 0;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            if (gnt_val_o) begin
                check($sformatf("t3_gnt%0d", k), 32'(gnt_num_o), 32'(exp_seq[k]));
                k++;
            end
            if (req_val_o) begin
                req_num_i = rr_pick(req_o, ptr);
                ptr = (int'(req_num_i) + 1) % REQCNT;
            end
            tick();
        end
        check("t3_gnt_count", 32'(k), 32'd4);
        check("t3_idle", 32'(dut.state), 32'(IDLE));
        check("t3_req_clr", 32'(req_o), 32'h0);

        // Bad grants: unrequested index, then out-of-range index
        req_set_i = 5'b00010;
        tick();
        req_set_i = '0;
        tick();
        check("t4_req", 32'(req_o), 32'b00010);
        req_num_i = 3'd3;
        tick();
        check("t4_bad", 32'(bad_gnt_o), 32'h1);
        check("t4_no_gv", 32'(gnt_val_o), 32'h0);
        check("t4_cnt1", 32'(dut.cnt[1]), 32'd1);
        tick();
        check("t4_reissue", 32'(req_val_o), 32'h1);
        req_num_i = 3'd6;
        tick();
        check("t4_no_gv2", 32'(gnt_val_o), 32'h0);
        check("t4_cnt1b", 32'(dut.cnt[1]), 32'd1);
        tick();
        req_num_i = 3'd1;
        tick();
        check("t4_good_gnt", 32'(gnt_num_o), 32'd1);
        tick();
        check("t4_cnt1_done", 32'(dut.cnt[1]), 32'd0);

        // Saturation of client 4 (issues answered with an invalid index)
        req_num_i = 3'd7;
        req_set_i = 5'b10000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                check("t5_cnt7", 32'(dut.cnt[4]), 32'd7);
                check("t5_full7", 32'(req_full_o), 32'b10000);
                check("t5_ovf7", 32'(ovf_o), 32'h0);
            end
        end
        req_set_i = '0;
        check("t5_cnt8", 32'(dut.cnt[4]), 32'd7);
        check("t5_full8", 32'(req_full_o), 32'b10000);
        check("t5_ovf8", 32'(ovf_o), 32'h1);

        // Reset clears counters and sticky flags
        rst_i = 1'b0;
        tick();
        check("t6_cnt4", 32'(dut.cnt[4]), 32'd0);
        check("t6_full", 32'(req_full_o), 32'h0);
        check("t6_sticky", 32'({bad_gnt_o, ovf_o}), 32'h0);
        rst_i = 1'b1;
        tick();

        // Set and retire on client 1 in the same cycle
        gnt_rdy_i = 1'b0;
        req_set_i = 5'b00010;
        tick();
        req_set_i = '0;
        tick();
        req_num_i = 3'd1;
        req_set_i = 5'b00010;
        tick();
        req_set_i = '0;
        check("t7_cnt1_same", 32'(dut.cnt[1]), 32'd1);
        check("t7_gv", 32'(gnt_val_o), 32'h1);
        req_set_i = 5'b01000;
        tick();
        req_set_i = '0;
        check("t7_cnt3", 32'(dut.cnt[3]), 32'd1);

        // Reset during WAIT drops the grant without a handshake
        rst_i = 1'b0;
        tick();
        check("t8_gv", 32'(gnt_val_o), 32'h0);
        check("t8_oh", 32'(gnt_oh_o), 32'h0);
        check("t8_state", 32'(dut.state), 32'(IDLE));
        check("t8_cnts", 32'({dut.cnt[0], dut.cnt[1], dut.cnt[2], dut.cnt[3], dut.cnt[4]}), 32'h0);
        rst_i = 1'b1;
        gnt_rdy_i = 1'b1;
        tick();
        tick();
        check("t8_quiet_rv", 32'(req_val_o), 32'h0);
        check("t8_quiet_state", 32'(dut.state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
